// File: rtl/npc_mem_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding, width defaults.
package npc_mem_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef logic owner_t;
  localparam owner_t OWN_IF = 1'b0;
  localparam owner_t OWN_LS = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LS has fixed priority.
module mem_arb_pick
  import npc_mem_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ls_req_i,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_i,
`endif
  output logic   vld_o,
  output owner_t own_o
);

  always_comb begin
    vld_o = if_req_i | ls_req_i;
    own_o = OWN_LS;
    if (if_req_i && !ls_req_i) begin
      own_o = OWN_IF;
    end else if (if_req_i && ls_req_i) begin
`ifdef MEM_ARB_RR_EN
      own_o = (last_i == OWN_LS) ? OWN_IF : OWN_LS;
`else
      own_o = OWN_LS;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: LS over IF).
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                arb_busy_o
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                grant_vld;
  owner_t              grant_own;

`ifdef MEM_ARB_RR_EN
  owner_t last_q, last_d;
`endif

  mem_arb_pick u_pick (
    .if_req_i (if_req_i),
    .ls_req_i (ls_req_i),
`ifdef MEM_ARB_RR_EN
    .last_i   (last_q),
`endif
    .vld_o    (grant_vld),
    .own_o    (grant_own)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_own;
          state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_own;
`endif
          if (grant_own == OWN_LS) begin
            we_d    = ls_we_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
            wmask_d = ls_wmask_i;
          end else begin
            // fetches are reads; clear store fields so the port never sees stale mask
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ISSUE, WAIT: begin
        if (mem_rvalid_i) begin
          state_d = RESP;
          if (owner_q == OWN_LS) ls_rdata_d = mem_rdata_i;
          else                   if_rdata_d = mem_rdata_i;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_LS;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= OWN_LS;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign mem_req_o   = (state_q == ISSUE);
  assign arb_busy_o  = (state_q != IDLE);
  assign if_rvalid_o = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_rvalid_o = (state_q == RESP) && (owner_q == OWN_LS);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_rvalid_o;
  logic [63:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [63:0] ls_addr_i;
  logic [63:0] ls_wdata_i;
  logic [7:0]  ls_wmask_i;
  logic        ls_rvalid_o;
  logic [63:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        arb_busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .arb_busy_o(arb_busy_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req_i = 0; if_addr_i = '0; ls_req_i = 0; ls_we_i = 0;
    ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0; mem_rvalid_i = 0; mem_rdata_i = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_busy", arb_busy_o, 0);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_ifrv", if_rvalid_o, 0);
    chk("rst_lsrv", ls_rvalid_o, 0);
    chk("rst_ifrd", if_rdata_o, 0);
    chk("rst_lsrd", ls_rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);

    // fetch, memory answers in ISSUE
    if_req_i = 1; if_addr_i = 64'h8000_0000;
    tick;
    chk("f_memreq", mem_req_o, 1);
    chk("f_addr", mem_addr_o, 64'h8000_0000);
    chk("f_we", mem_we_o, 0);
    chk("f_mask", mem_wmask_o, 0);
    chk("f_busy", arb_busy_o, 1);
    chk("f_rv_early", if_rvalid_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 64'h0000_0000_0010_0073;
    tick;
    mem_rvalid_i = 0;
    chk("f_rv", if_rvalid_o, 1);
    chk("f_rdata", if_rdata_o, 64'h0000_0000_0010_0073);
    chk("f_lsrv", ls_rvalid_o, 0);
    chk("f_memreq_off", mem_req_o, 0);
    if_req_i = 0;
    tick;
    chk("f_rv_pulse", if_rvalid_o, 0);
    chk("f_idle", arb_busy_o, 0);

    // store, ack in third WAIT cycle
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 64'h8000_1000;
    ls_wdata_i = 64'hDEAD_BEEF; ls_wmask_i = 8'h0F;
    tick;
    chk("s_memreq", mem_req_o, 1);
    chk("s_we", mem_we_o, 1);
    chk("s_mask", mem_wmask_o, 8'h0F);
    chk("s_wdata", mem_wdata_o, 64'hDEAD_BEEF);
    chk("s_addr", mem_addr_o, 64'h8000_1000);
    tick;
    chk("s_w1_req", mem_req_o, 0);
    chk("s_w1_rv", ls_rvalid_o, 0);
    tick;
    chk("s_w2_rv", ls_rvalid_o, 0);
    tick;
    chk("s_w3_rv", ls_rvalid_o, 0);
    chk("s_w3_busy", arb_busy_o, 1);
    mem_rvalid_i = 1; mem_rdata_i = 64'h55;
    tick;
    mem_rvalid_i = 0;
    chk("s_rv", ls_rvalid_o, 1);
    chk("s_ifrv", if_rvalid_o, 0);
    chk("s_lsrd", ls_rdata_o, 64'h55);
    chk("s_ifrd_hold", if_rdata_o, 64'h0000_0000_0010_0073);
    ls_req_i = 0; ls_we_i = 0;
    tick;
    chk("s_rv_pulse", ls_rvalid_o, 0);

    // fetch address changes while in WAIT
    if_req_i = 1; if_addr_i = 64'h8000_0000;
    tick;
    chk("a_issue", mem_req_o, 1);
    tick;
    if_addr_i = 64'h8000_0004;
    chk("a_wait_addr", mem_addr_o, 64'h8000_0000);
    tick;
    chk("a_wait2_addr", mem_addr_o, 64'h8000_0000);
    mem_rvalid_i = 1; mem_rdata_i = 64'h1234;
    tick;
    mem_rvalid_i = 0;
    chk("a_rv", if_rvalid_o, 1);
    chk("a_resp_addr", mem_addr_o, 64'h8000_0000);
    chk("a_rdata", if_rdata_o, 64'h1234);
    if_req_i = 0;
    tick;

    // stray completion in IDLE
    mem_rvalid_i = 1; mem_rdata_i = 64'hBAD;
    tick;
    chk("st_busy", arb_busy_o, 0);
    chk("st_ifrv", if_rvalid_o, 0);
    chk("st_lsrv", ls_rvalid_o, 0);
    tick;
    mem_rvalid_i = 0;
    chk("st_ifrv2", if_rvalid_o, 0);
    chk("st_lsrv2", ls_rvalid_o, 0);
    chk("st_ifrd", if_rdata_o, 64'h1234);
    chk("st_lsrd", ls_rdata_o, 64'h55);

    // reset during WAIT, late completion afterwards
    ls_req_i = 1; ls_addr_i = 64'h3000;
    tick;
    tick;
    chk("r_wait", arb_busy_o, 1);
    rst = 1;
    tick;
    rst = 0; ls_req_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 64'hFEED;
    chk("r_busy", arb_busy_o, 0);
    chk("r_lsrv", ls_rvalid_o, 0);
    chk("r_memreq", mem_req_o, 0);
    chk("r_addr", mem_addr_o, 0);
    chk("r_lsrd", ls_rdata_o, 0);
    chk("r_ifrd", if_rdata_o, 0);
    tick;
    mem_rvalid_i = 0;
    chk("r_lsrv2", ls_rvalid_o, 0);
    chk("r_busy2", arb_busy_o, 0);
    chk("r_lsrd2", ls_rdata_o, 0);

    // both requesters held for four transactions
    if_req_i = 1; if_addr_i = 64'h1000;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      logic exp_ls;
`ifdef MEM_ARB_RR_EN
      exp_ls = (i % 2) == 1;
`else
      exp_ls = 1'b1;
`endif
      tick;
      chk("b_addr", mem_addr_o, exp_ls ? 64'h2000 : 64'h1000);
      mem_rvalid_i = 1; mem_rdata_i = 64'(i + 100);
      tick;
      mem_rvalid_i = 0;
      chk("b_lsrv", ls_rvalid_o, exp_ls);
      chk("b_ifrv", if_rvalid_o, !exp_ls);
      if (i == 3) begin
        if_req_i = 0; ls_req_i = 0;
      end
      tick;
    end
    chk("b_idle", arb_busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
